// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_WAIT_VALID,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_e;

    localparam int FRAME_BITS          = 10;
    localparam int DATA_BITS           = 8;
    localparam int BAUD_DIV_50M_115200 = 434;

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period timer: one-cycle tick on the last cycle of every bit.
// Restart zeroes the count so the first bit after it is full width.
module baud_tick_gen #(
    parameter int BAUD_DIV = 434
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic restart,
    output logic tick
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || cnt_q == LAST) cnt_d = '0;
    end

    always_ff @(posedge Clk or posedge Reset_n) begin
        if (Reset_n) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a standard-mode FIFO read port and sends each as an 8N1
// frame, LSB first. Reports sent-byte count and sticky read faults.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int BAUD_DIV      = BAUD_DIV_50M_115200,
    parameter int VALID_TIMEOUT = 4,
    parameter int CNT_W         = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             fifo_empty,
    input  logic             fifo_valid,
    input  logic             fifo_underflow,
    input  logic [7:0]       fifo_dout,
    output logic             fifo_rd_en,
    output logic             uart_tx,
    output logic             tx_busy,
    output logic             tx_done,
    output logic [CNT_W-1:0] tx_count,
    output logic             rd_fault
);
    localparam int TW = $clog2(VALID_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(VALID_TIMEOUT - 1);

    tx_state_e        state_q, state_d;
    logic [TW-1:0]    to_cnt_q, to_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [CNT_W-1:0] tx_count_q, tx_count_d;
    logic             rd_en_q, rd_en_d;
    logic             uart_tx_q, uart_tx_d;
    logic             tx_done_q, tx_done_d;
    logic             rd_fault_q, rd_fault_d;
    logic             restart, tick, timeout;

    baud_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        tx_count_d = tx_count_q;
        tx_done_d  = 1'b0;
        uart_tx_d  = 1'b1;
        restart    = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            S_IDLE: if (!fifo_empty) state_d = S_POP;
            S_POP: begin
                to_cnt_d = '0;
                state_d  = S_WAIT_VALID;
            end
            S_WAIT_VALID: begin
                if (fifo_valid) begin
                    shreg_d   = fifo_dout;
                    bit_idx_d = '0;
                    restart   = 1'b1;
                    state_d   = S_START;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_START: begin
                uart_tx_d = 1'b0;
                if (tick) state_d = S_DATA;
            end
            S_DATA: begin
                uart_tx_d = shreg_q[0];
                if (tick) begin
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    tx_done_d  = 1'b1;
                    tx_count_d = tx_count_q + 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Strobe is registered off the next state so it is high exactly while in POP.
        rd_en_d    = (state_d == S_POP);
        rd_fault_d = rd_fault_q | timeout | fifo_underflow;
    end

    always_ff @(posedge Clk or posedge Reset_n) begin
        if (Reset_n) begin
            state_q    <= S_IDLE;
            to_cnt_q   <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            tx_count_q <= '0;
            rd_en_q    <= 1'b0;
            uart_tx_q  <= 1'b1;
            tx_done_q  <= 1'b0;
            rd_fault_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            tx_count_q <= tx_count_d;
            rd_en_q    <= rd_en_d;
            uart_tx_q  <= uart_tx_d;
            tx_done_q  <= tx_done_d;
            rd_fault_q <= rd_fault_d;
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign uart_tx    = uart_tx_q;
    assign tx_busy    = (state_q != S_IDLE);
    assign tx_done    = tx_done_q;
    assign tx_count   = tx_count_q;
    assign rd_fault   = rd_fault_q;

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream consumer of the 16-in/8-out synchronous FIFO. It pops one byte at a time through the FIFO's standard-mode read port, using rd_en, empty, valid and dout. Each byte is serialised as an 8N1 UART frame, LSB first. This block drains the FIFO to the board TX pin and reports progress, read underflow and read-latency faults.

Parameters:
BAUD_DIV, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2.
VALID_TIMEOUT, 4, maximum cycles to wait for fifo_valid after a pop before flagging a fault.
CNT_W, 16, width of the sent-byte counter.

Ports:
Clk  input  1  system clock, 50 MHz.
Reset_n  input  1  asynchronous, active-high reset; the name follows the codebase convention, the polarity is high.
fifo_empty  input  1  FIFO empty flag.
fifo_valid  input  1  FIFO read-data valid, one cycle after an accepted rd_en.
fifo_underflow  input  1  FIFO underflow flag.
fifo_dout  input  8  FIFO read data.
fifo_rd_en  output  1  FIFO read strobe, registered.
uart_tx  output  1  serial line, idles high, registered.
tx_busy  output  1  high from POP until the end of STOP.
tx_done  output  1  one-cycle pulse at the end of each stop bit.
tx_count  output  CNT_W  bytes fully sent, wraps modulo 2^CNT_W.
rd_fault  output  1  sticky; set on a valid timeout or on fifo_underflow; cleared only by reset.

Behaviour:
- Reset (asynchronous, Reset_n=1): the FSM goes to IDLE.
  - Output reset values: fifo_rd_en=0, uart_tx=1, tx_busy=0, tx_done=0, tx_count=0, rd_fault=0.
  - The baud counter and bit index are cleared and the shift register becomes 0.
  - Reset mid-frame drops the byte in flight, and the line returns high immediately.
- FSM states: IDLE, POP, WAIT_VALID, START, DATA, STOP.
- IDLE: on a rising edge with fifo_empty=0, go to POP.
- POP: exactly one cycle.
  - fifo_rd_en=1 during this cycle only; it is never high in any other state.
  - Next state is WAIT_VALID, with the timeout counter cleared.
- WAIT_VALID: fifo_valid is sampled every edge.
  - If fifo_valid=1: latch fifo_dout into the shift register and go to START.
  - If fifo_valid=0 for VALID_TIMEOUT consecutive edges: set rd_fault and return to IDLE. No frame is sent and tx_count is unchanged.
- START: uart_tx=0 for BAUD_DIV cycles.
- DATA: 8 bits, each held for BAUD_DIV cycles.
  - Bit order is data[0] first, data[7] last; the shift register shifts right per bit.
- STOP: uart_tx=1 for BAUD_DIV cycles.
  - On the last cycle: tx_done=1 for one cycle, tx_count increments, and the FSM goes to IDLE.
- Baud counter: counts 0..BAUD_DIV-1 and wraps on each bit boundary. Its width is $clog2(BAUD_DIV).
- Latency with the FIFO's 1-cycle read latency:
  - Let edge E be the one that samples fifo_empty=0 in IDLE. uart_tx falls at edge E+3.
  - A frame lasts 10*BAUD_DIV cycles.
  - Back-to-back frames are separated by exactly 3 idle-high cycles, the IDLE→POP→WAIT_VALID overhead.
- fifo_empty is ignored outside IDLE. Writes to the FIFO during a frame have no effect until the next IDLE.
- fifo_underflow=1 in any state sets rd_fault and does not alter the FSM.
- tx_busy is combinational from state: 1 in every state except IDLE.
- uart_tx comes from a dedicated flop, so there are no glitches.

Decomposition:
- Package fifo_uart_pkg holds:
  - the state enum typedef (6 states, 3-bit encoding);
  - the constants FRAME_BITS=10 and DATA_BITS=8;
  - the default BAUD_DIV_50M_115200=434.
- One sub-module, baud_tick_gen. It is parameterised by BAUD_DIV and has inputs Clk, Reset_n and a restart input, and one output: a one-cycle tick at each bit boundary.
- The tick restarts on entry to START, so bit 0 is full width.

Test Plan:
All cases use BAUD_DIV=4 and VALID_TIMEOUT=4, with the Xilinx FIFO model connected and the same 20 ns Clk.
1. Reset check: hold Reset_n=1 for 205 ns, then release → uart_tx=1, fifo_rd_en=0, tx_count=0, rd_fault=0; no pop while empty=1.
2. Single word: write din=16'h0102 (2 bytes) → two frames, 40 cycles each.
   - Decoded bytes match the FIFO's byte-out order for 16'h0102.
   - The gap between the frames is 3 cycles.
   - tx_done pulses twice; tx_count=2; FIFO empty at the end.
3. Burst: write 300 words (din = 1..300) → 600 frames, decoded in FIFO read order.
   - fifo_rd_en pulses exactly 600 times, each 1 cycle wide.
   - tx_count=600; overflow never asserted on the read side.
4. Timeout: stub the FIFO so fifo_valid stays 0 after rd_en → rd_fault=1 four edges after POP.
   - The FSM returns to IDLE; uart_tx stays 1; tx_count is unchanged.
5. Reset mid-frame: assert Reset_n during DATA bit 3 → uart_tx=1 within the same timestep.
   - After release, the next FIFO byte is sent complete and correct; the dropped byte is not retransmitted.
6. Bit timing with BAUD_DIV=434: send byte 8'h55 → each low and high period measures 8680 ns ±0, and the stop bit is 8680 ns high.
